// File: rtl/l2_sink_d.sv
// l2_sink_d: memory-side D-channel receiver.
// Assembles response beats into lines and strobes the owning MSHR.
`ifndef OP_BITS
`define OP_BITS 3
`endif
`ifndef SOURCE_BITS
`define SOURCE_BITS 4
`endif
`ifndef DATA_BITS
`define DATA_BITS 128
`endif

module l2_sink_d #(
  parameter int MSHRS      = 4,
  parameter int IDX_BITS   = 2,
  parameter int BEATS      = 4,
  parameter int ACK_OP     = 0,
  parameter int ACKDATA_OP = 1,
  parameter int BEAT_BITS  = `DATA_BITS / BEATS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_d_valid_i,
  output logic                    mem_d_ready_o,
  input  logic [`OP_BITS-1:0]     mem_d_opcode_i,
  input  logic [`SOURCE_BITS-1:0] mem_d_source_i,
  input  logic [BEAT_BITS-1:0]    mem_d_data_i,
  input  logic [MSHRS-1:0]        mshr_valid_i,
  output logic [MSHRS-1:0]        sinked_valid_o,
  output logic [`OP_BITS-1:0]     sinked_opcode_o,
  output logic [`SOURCE_BITS-1:0] sinked_source_o,
  output logic [`DATA_BITS-1:0]   sinked_data_o,
  output logic                    err_o,
  input  logic                    err_clr_i
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OPW   = `OP_BITS;
  localparam int SRCW  = `SOURCE_BITS;
  localparam int DW    = `DATA_BITS;

  typedef enum logic {
    IDLE,
    COLLECT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    line_q, line_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [SRCW-1:0]  src_q, src_d;
  logic [MSHRS-1:0] sv_q, sv_d;
  logic [OPW-1:0]   sop_q, sop_d;
  logic [SRCW-1:0]  ssrc_q, ssrc_d;
  logic [DW-1:0]    sdata_q, sdata_d;
  logic             err_q, err_d;

  logic             acc;
  logic             is_ack;
  logic             is_ackd;
  logic             match;
  logic             last;
  logic             dlv;
  logic             dlv_ok;
  logic             err_set;
  logic [OPW-1:0]   dlv_op;
  logic [SRCW-1:0]  dlv_src;
  logic [DW-1:0]    dlv_data;
  logic [DW-1:0]    line_n;

  // No backpressure on the sinked path: accept whenever out of reset.
  assign mem_d_ready_o = rst_n;
  assign acc     = mem_d_valid_i & mem_d_ready_o;
  assign is_ack  = (mem_d_opcode_i == OPW'(ACK_OP));
  assign is_ackd = (mem_d_opcode_i == OPW'(ACKDATA_OP));
  assign match   = (mem_d_opcode_i == op_q) &&
                   (mem_d_source_i == src_q);
  assign last    = (cnt_q == CNT_W'(BEATS - 1));

  // Beat assembly, state transitions and delivery decision.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    line_d   = line_q;
    op_d     = op_q;
    src_d    = src_q;
    sv_d     = '0;
    sop_d    = sop_q;
    ssrc_d   = ssrc_q;
    sdata_d  = sdata_q;
    err_set  = 1'b0;
    dlv      = 1'b0;
    dlv_ok   = 1'b0;
    dlv_op   = mem_d_opcode_i;
    dlv_src  = mem_d_source_i;
    dlv_data = '0;
    line_n   = line_q;
    for (int b = 0; b < BEATS; b++) begin
      if (cnt_q == CNT_W'(b)) begin
        line_n[b*BEAT_BITS +: BEAT_BITS] = mem_d_data_i;
      end
    end
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          unique case (1'b1)
            is_ack: begin
              dlv = 1'b1;
            end
            is_ackd: begin
              if (BEATS == 1) begin
                dlv = 1'b1;
                dlv_data[BEAT_BITS-1:0] = mem_d_data_i;
              end else begin
                op_d    = mem_d_opcode_i;
                src_d   = mem_d_source_i;
                line_d  = '0;
                line_d[BEAT_BITS-1:0] = mem_d_data_i;
                cnt_d   = CNT_W'(1);
                state_d = COLLECT;
              end
            end
            default: begin
              err_set = 1'b1;
            end
          endcase
        end
      end
      COLLECT: begin
        if (acc) begin
          if (match) begin
            line_d = line_n;
            if (last) begin
              dlv      = 1'b1;
              dlv_op   = op_q;
              dlv_src  = src_q;
              dlv_data = line_n;
              cnt_d    = '0;
              state_d  = IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            err_set = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (dlv) begin
      for (int i = 0; i < MSHRS; i++) begin
        if (dlv_src[IDX_BITS-1:0] == IDX_BITS'(i) &&
            mshr_valid_i[i]) begin
          dlv_ok  = 1'b1;
          sv_d[i] = 1'b1;
        end
      end
      if (dlv_ok) begin
        sop_d   = dlv_op;
        ssrc_d  = dlv_src;
        sdata_d = dlv_data;
      end else begin
        err_set = 1'b1;
      end
    end
    err_d = err_set ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
  end

  // State, line buffer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      op_q    <= '0;
      src_q   <= '0;
      sv_q    <= '0;
      sop_q   <= '0;
      ssrc_q  <= '0;
      sdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      op_q    <= op_d;
      src_q   <= src_d;
      sv_q    <= sv_d;
      sop_q   <= sop_d;
      ssrc_q  <= ssrc_d;
      sdata_q <= sdata_d;
      err_q   <= err_d;
    end
  end

  assign sinked_valid_o  = sv_q;
  assign sinked_opcode_o = sop_q;
  assign sinked_source_o = ssrc_q;
  assign sinked_data_o   = sdata_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_l2_sink_d.sv
// tb_l2_sink_d: directed bench for l2_sink_d.
// Scenario tasks with hand-computed expectations.
`ifndef OP_BITS
`define OP_BITS 3
`endif
`ifndef SOURCE_BITS
`define SOURCE_BITS 4
`endif
`ifndef DATA_BITS
`define DATA_BITS 128
`endif

module tb_l2_sink_d;

  localparam logic [2:0] ACK  = 3'd0;
  localparam logic [2:0] ACKD = 3'd1;

  logic         clk;
  logic         rst_n;
  logic         mem_d_valid_i;
  logic         mem_d_ready_o;
  logic [2:0]   mem_d_opcode_i;
  logic [3:0]   mem_d_source_i;
  logic [31:0]  mem_d_data_i;
  logic [3:0]   mshr_valid_i;
  logic [3:0]   sinked_valid_o;
  logic [2:0]   sinked_opcode_o;
  logic [3:0]   sinked_source_o;
  logic [127:0] sinked_data_o;
  logic         err_o;
  logic         err_clr_i;

  int total;
  int passed;

  l2_sink_d dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_d_valid_i   (mem_d_valid_i),
    .mem_d_ready_o   (mem_d_ready_o),
    .mem_d_opcode_i  (mem_d_opcode_i),
    .mem_d_source_i  (mem_d_source_i),
    .mem_d_data_i    (mem_d_data_i),
    .mshr_valid_i    (mshr_valid_i),
    .sinked_valid_o  (sinked_valid_o),
    .sinked_opcode_o (sinked_opcode_o),
    .sinked_source_o (sinked_source_o),
    .sinked_data_o   (sinked_data_o),
    .err_o           (err_o),
    .err_clr_i       (err_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic beat(input logic [2:0] op, input logic [3:0] src,
                      input logic [31:0] d);
    mem_d_valid_i  = 1'b1;
    mem_d_opcode_i = op;
    mem_d_source_i = src;
    mem_d_data_i   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_d_valid_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if (mem_d_ready_o !== 1'b0 || sinked_valid_o !== 4'b0 ||
        sinked_opcode_o !== 3'b0 || sinked_source_o !== 4'b0 ||
        sinked_data_o !== 128'b0 || err_o !== 1'b0)
      $display("FAIL reset: rdy=%b sv=%b op=%h src=%h d=%h err=%b",
               mem_d_ready_o, sinked_valid_o, sinked_opcode_o,
               sinked_source_o, sinked_data_o, err_o);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (mem_d_ready_o !== 1'b1)
      $display("FAIL ready_after_reset: got %b want 1", mem_d_ready_o);
    else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    mshr_valid_i = 4'b0100;
    beat(ACKD, 4'h2, 32'h11111111);
    beat(ACKD, 4'h2, 32'h22222222);
    beat(ACKD, 4'h2, 32'h33333333);
    total++;
    if (sinked_valid_o !== 4'b0)
      $display("FAIL fill_early: sv=%b want 0000", sinked_valid_o);
    else passed++;
    beat(ACKD, 4'h2, 32'h44444444);
    mem_d_valid_i = 1'b0;
    total++;
    if (sinked_valid_o !== 4'b0100 ||
        sinked_data_o !== 128'h44444444_33333333_22222222_11111111 ||
        sinked_opcode_o !== ACKD || sinked_source_o !== 4'h2 ||
        err_o !== 1'b0)
      $display("FAIL fill: sv=%b d=%h op=%h src=%h err=%b",
               sinked_valid_o, sinked_data_o, sinked_opcode_o,
               sinked_source_o, err_o);
    else passed++;
    idle();
    total++;
    if (sinked_valid_o !== 4'b0 ||
        sinked_data_o !== 128'h44444444_33333333_22222222_11111111)
      $display("FAIL fill_hold: sv=%b d=%h want 0000 and held line",
               sinked_valid_o, sinked_data_o);
    else passed++;
  endtask

  task automatic test_ack();
    mshr_valid_i = 4'b0010;
    beat(ACK, 4'h1, 32'hDEADBEEF);
    total++;
    if (sinked_valid_o !== 4'b0010 || sinked_opcode_o !== ACK ||
        sinked_data_o !== 128'b0 || sinked_source_o !== 4'h1)
      $display("FAIL ack: sv=%b op=%h d=%h src=%h want 0010/0/0/1",
               sinked_valid_o, sinked_opcode_o, sinked_data_o,
               sinked_source_o);
    else passed++;
    beat(ACK, 4'h1, 32'h0);
    total++;
    if (sinked_valid_o !== 4'b0010)
      $display("FAIL ack_b2b: sv=%b want 0010", sinked_valid_o);
    else passed++;
    idle();
    total++;
    if (sinked_valid_o !== 4'b0)
      $display("FAIL ack_end: sv=%b want 0000", sinked_valid_o);
    else passed++;
  endtask

  task automatic test_switch();
    mshr_valid_i = 4'b1001;
    beat(ACKD, 4'h0, 32'hAAAA0000);
    beat(ACKD, 4'h0, 32'hAAAA0001);
    beat(ACKD, 4'h3, 32'hBBBB0000);
    mem_d_valid_i = 1'b0;
    total++;
    if (sinked_valid_o !== 4'b0 || err_o !== 1'b1)
      $display("FAIL switch_err: sv=%b err=%b want 0000/1",
               sinked_valid_o, err_o);
    else passed++;
    beat(ACKD, 4'h3, 32'hC0000000);
    beat(ACKD, 4'h3, 32'hC0000001);
    beat(ACKD, 4'h3, 32'hC0000002);
    beat(ACKD, 4'h3, 32'hC0000003);
    mem_d_valid_i = 1'b0;
    total++;
    if (sinked_valid_o !== 4'b1000 ||
        sinked_data_o !== 128'hC0000003_C0000002_C0000001_C0000000 ||
        err_o !== 1'b1)
      $display("FAIL switch_recover: sv=%b d=%h err=%b",
               sinked_valid_o, sinked_data_o, err_o);
    else passed++;
    err_clr_i = 1'b1;
    idle();
    err_clr_i = 1'b0;
    total++;
    if (err_o !== 1'b0)
      $display("FAIL err_clear: err=%b want 0", err_o);
    else passed++;
    err_clr_i = 1'b1;
    beat(3'd5, 4'h0, 32'h0);
    err_clr_i = 1'b0;
    mem_d_valid_i = 1'b0;
    total++;
    if (err_o !== 1'b1 || sinked_valid_o !== 4'b0)
      $display("FAIL err_set_dominates: err=%b sv=%b want 1/0000",
               err_o, sinked_valid_o);
    else passed++;
    err_clr_i = 1'b1;
    idle();
    err_clr_i = 1'b0;
  endtask

  task automatic test_unalloc();
    mshr_valid_i = 4'b0000;
    beat(ACKD, 4'h1, 32'h5);
    beat(ACKD, 4'h1, 32'h6);
    beat(ACKD, 4'h1, 32'h7);
    beat(ACKD, 4'h1, 32'h8);
    mem_d_valid_i = 1'b0;
    total++;
    if (sinked_valid_o !== 4'b0 || err_o !== 1'b1 ||
        sinked_data_o !== 128'hC0000003_C0000002_C0000001_C0000000 ||
        sinked_source_o !== 4'h3)
      $display("FAIL unalloc: sv=%b err=%b d=%h src=%h",
               sinked_valid_o, err_o, sinked_data_o, sinked_source_o);
    else passed++;
    err_clr_i = 1'b1;
    idle();
    err_clr_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    mshr_valid_i = 4'b0011;
    beat(ACKD, 4'h0, 32'h0A000000);
    beat(ACKD, 4'h0, 32'h0A000001);
    beat(ACKD, 4'h0, 32'h0A000002);
    beat(ACKD, 4'h0, 32'h0A000003);
    total++;
    if (sinked_valid_o !== 4'b0001 ||
        sinked_data_o !== 128'h0A000003_0A000002_0A000001_0A000000)
      $display("FAIL b2b_first: sv=%b d=%h", sinked_valid_o,
               sinked_data_o);
    else passed++;
    beat(ACKD, 4'h1, 32'h0B000000);
    total++;
    if (sinked_valid_o !== 4'b0)
      $display("FAIL b2b_gap: sv=%b want 0000", sinked_valid_o);
    else passed++;
    beat(ACKD, 4'h1, 32'h0B000001);
    beat(ACKD, 4'h1, 32'h0B000002);
    beat(ACKD, 4'h1, 32'h0B000003);
    total++;
    if (sinked_valid_o !== 4'b0010 || sinked_source_o !== 4'h1 ||
        sinked_data_o !== 128'h0B000003_0B000002_0B000001_0B000000 ||
        err_o !== 1'b0)
      $display("FAIL b2b_second: sv=%b src=%h d=%h err=%b",
               sinked_valid_o, sinked_source_o, sinked_data_o, err_o);
    else passed++;
    beat(ACKD, 4'h0, 32'hEEEE0000);
    beat(ACKD, 4'h0, 32'hEEEE0001);
    mem_d_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (mem_d_ready_o !== 1'b0 || sinked_valid_o !== 4'b0 ||
        sinked_opcode_o !== 3'b0 || sinked_source_o !== 4'b0 ||
        sinked_data_o !== 128'b0 || err_o !== 1'b0)
      $display("FAIL midburst_reset: rdy=%b sv=%b d=%h err=%b",
               mem_d_ready_o, sinked_valid_o, sinked_data_o, err_o);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(ACKD, 4'h1, 32'hF0000000);
    beat(ACKD, 4'h1, 32'hF0000001);
    beat(ACKD, 4'h1, 32'hF0000002);
    beat(ACKD, 4'h1, 32'hF0000003);
    mem_d_valid_i = 1'b0;
    total++;
    if (sinked_valid_o !== 4'b0010 || err_o !== 1'b0 ||
        sinked_data_o !== 128'hF0000003_F0000002_F0000001_F0000000)
      $display("FAIL post_reset_burst: sv=%b d=%h err=%b",
               sinked_valid_o, sinked_data_o, err_o);
    else passed++;
    idle();
  endtask

  initial begin
    total          = 0;
    passed         = 0;
    mem_d_valid_i  = 1'b0;
    mem_d_opcode_i = 3'b0;
    mem_d_source_i = 4'b0;
    mem_d_data_i   = 32'b0;
    mshr_valid_i   = 4'b0;
    err_clr_i      = 1'b0;
    test_reset();
    test_fill();
    test_ack();
    test_switch();
    test_unalloc();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/l2_sink_d.md
# l2_sink_d

L2 memory-side D-channel receiver. Accepts response beats from the memory-side bus, assembles them into full cache lines, and delivers each completed response to the owning MSHR as a one-cycle sinked pulse with opcode, source and line data. It sits between the memory port and the MSHR array, and is the return path for the GET requests the MSHRs issue on schedule A.

## Interface
Parameters:
- MSHRS, 4, number of MSHRs; one sinked strobe per MSHR.
- IDX_BITS, 2, width of the MSHR index carried in mem_d_source_i[IDX_BITS-1:0].
- BEATS, 4, beats per line. BEAT_BITS = `DATA_BITS/BEATS, i.e. 32 for 128-bit lines.
- ACK_OP, 0, opcode value of AccessAck (no data).
- ACKDATA_OP, 1, opcode value of AccessAckData.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_d_valid_i  in  1  memory response beat valid.
- mem_d_ready_o  out  1  beat accept.
- mem_d_opcode_i  in  `OP_BITS  response opcode.
- mem_d_source_i  in  `SOURCE_BITS  response source; the low IDX_BITS are the MSHR index.
- mem_d_data_i  in  BEAT_BITS  beat data.
- mshr_valid_i  in  MSHRS  per-MSHR allocated flag.
- sinked_valid_o  out  MSHRS  one-hot, one-cycle sinked strobe.
- sinked_opcode_o  out  `OP_BITS  opcode of the delivered response.
- sinked_source_o  out  `SOURCE_BITS  full source of the delivered response.
- sinked_data_o  out  `DATA_BITS  assembled line.
- err_o  out  1  sticky protocol error flag.
- err_clr_i  in  1  clears err_o.

## Operation
- The block has two states, IDLE and COLLECT. It holds a beat counter cnt of width clog2(BEATS) and registers for line, opcode and source.
- A beat is accepted when mem_d_valid_i && mem_d_ready_o. mem_d_ready_o is 1 whenever rst_n is high, because the sinked path has no backpressure.
- Beat k is written to line[k*BEAT_BITS +: BEAT_BITS], with beat 0 as the least significant.
- **IDLE, ACK_OP beat:** this is a single-beat response. Deliver it with data equal to 0. Stay in IDLE.
- **IDLE, ACKDATA_OP beat:**
  - Latch opcode and source, store beat 0, set cnt to 1, go to COLLECT.
  - If BEATS==1, deliver immediately instead.
- **IDLE, any other opcode:** drop the beat, set err.
- **COLLECT, matching beat** (same source and opcode as latched): store the beat, increment cnt. On the beat where cnt==BEATS-1, deliver and return to IDLE with cnt=0.
- **COLLECT, mismatching beat:** discard the partial line and the beat, set err, return to IDLE.
- **Delivery check.** Uses idx = source[IDX_BITS-1:0]. If idx < MSHRS and mshr_valid_i[idx] is 1 in the final-beat cycle:
  - sinked_valid_o[idx] pulses.
  - The sinked_* fields are updated.
  - Otherwise there is no pulse, the sinked_* fields are unchanged, and err is set.
- **err:** set dominates err_clr_i when both occur in the same cycle.

## Timing
- **Reset values:** mem_d_ready_o=0, sinked_valid_o=0, sinked_opcode_o=0, sinked_source_o=0, sinked_data_o=0, err_o=0. State is IDLE and cnt=0.
- **Reset asserted mid-burst:** the partial line is discarded and no pulse is produced.
- **Latency:** sinked_valid_o rises exactly 1 cycle after the final beat handshake and stays high for exactly 1 cycle.
- **sinked_* fields:** become valid in the same cycle as the pulse and hold until the next delivery.
- **Throughput:** one beat per cycle. The first beat of the next response may be accepted in the cycle the previous pulse is visible. Back-to-back ACK_OP responses produce pulses on consecutive cycles.
- **cnt:** never wraps past BEATS-1, because a completed line forces IDLE.
- **err_o:** asserts 1 cycle after the offending handshake and holds until the cycle after err_clr_i with no new error.

## Test plan
- **4-beat fill:** mshr_valid_i=4'b0100; ACKDATA_OP, source=0x2, data 0x11111111, 0x22222222, 0x33333333, 0x44444444 on 4 consecutive cycles -> at cycle 5 sinked_valid_o=4'b0100 for 1 cycle, sinked_data_o=0x44444444_33333333_22222222_11111111, err_o=0.
- **Single-beat ack:** ACK_OP, source=0x1, mshr_valid_i[1]=1 -> next cycle sinked_valid_o=4'b0010, sinked_opcode_o=0, sinked_data_o=0.
- **Mid-burst source switch:** 2 beats with source 0x0, then a beat with source 0x3 -> no pulse, err_o=1 the following cycle. A fresh 4-beat source 0x3 burst then delivers normally with err_o still 1. err_clr_i for 1 cycle -> err_o=0.
- **Unallocated MSHR:** complete 4-beat burst to source 0x1 with mshr_valid_i=4'b0000 -> no pulse, sinked_data_o unchanged, err_o=1.
- **Back-to-back with reset:**
  - Two 4-beat bursts with no idle gap, sources 0x0 then 0x1 -> pulses at cycles 5 and 9.
  - Then assert rst_n=0 after the 2nd beat of a third burst -> all outputs 0 immediately. After release, a new burst delivers correct data with no stale beats.
